// File: rtl/ahb_uart_regs.sv
// AHB-Lite register responder for the UART: TX byte FIFO, RX holding register, status, baud divisor.
// Latency: zero-wait OKAY data phase with combinational hrdata; an error adds one stall cycle (ERR1) before ERR2.
// Backpressure: the bus is stalled only in ERR1; the TX engine drains the FIFO via tx_valid/tx_ready.
//
// Ports:
//   clk, nReset (synchronous, active-high)
//   AHB-Lite: hsel, haddr, htrans, hwrite, hsize, hwdata, hready -> hreadyout, hresp, hrdata
//   RX engine: rx_byte, rx_strobe
//   TX engine: tx_byte, tx_valid, tx_ready
//   baud_div: divisor for both shift engines
module ahb_uart_regs #(
  parameter int          ADDR_W   = 32,
  parameter int          TX_DEPTH = 4,
  parameter logic [15:0] BAUD_RST = 16'd434
) (
  input  logic              clk,
  input  logic              nReset,
  input  logic              hsel,
  input  logic [ADDR_W-1:0] haddr,
  input  logic [1:0]        htrans,
  input  logic              hwrite,
  input  logic [2:0]        hsize,
  input  logic [31:0]       hwdata,
  input  logic              hready,
  output logic              hreadyout,
  output logic              hresp,
  output logic [31:0]       hrdata,
  input  logic [7:0]        rx_byte,
  input  logic              rx_strobe,
  output logic [7:0]        tx_byte,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic [15:0]       baud_div
);

  localparam int AW = $clog2(TX_DEPTH);
  localparam int PW = AW + 1;
  localparam logic [PW-1:0] DEPTH_P = PW'(TX_DEPTH);

  localparam logic [4:0] OFF_RXDATA  = 5'h00;
  localparam logic [4:0] OFF_TXDATA  = 5'h04;
  localparam logic [4:0] OFF_RXSTATE = 5'h08;
  localparam logic [4:0] OFF_TXSTATE = 5'h0C;
  localparam logic [4:0] OFF_BAUD    = 5'h10;

  typedef enum logic [1:0] {
    ST_OKAY = 2'd0,
    ST_ERR1 = 2'd1,
    ST_ERR2 = 2'd2
  } state_t;

  state_t          state;
  logic            pending;
  logic [4:0]      d_addr;
  logic            d_write;

  logic            accept;
  logic            addr_err;
  logic            commit;

  logic [7:0]      rx_hold;
  logic            rx_full;
  logic            rx_ovr;
  logic            rx_full_nxt;
  logic            rx_pop;
  logic            rx_ovr_clr;

  logic [7:0]      mem [TX_DEPTH];
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic [PW-1:0]   count;
  logic [PW-1:0]   count_nxt;
  logic [7:0]      cnt8;
  logic            full;
  logic            empty;
  logic            tx_push;
  logic            tx_pop;

  logic [15:0]     baud_q;

  // Bits that the five-word map never looks at.
  logic unused_bits;
  assign unused_bits = &{1'b0, haddr[ADDR_W-1:5], htrans[0], hwdata[31:16]};

  // Error decode for a transfer, given the occupancy state it will see in its data phase.
  function automatic logic decode_err(input logic [4:0] a, input logic wr, input logic [2:0] sz,
                                      input logic rxf, input logic txf);
    logic e;
    e = 1'b0;
    if (a[1:0] != 2'b00 || a > OFF_BAUD || sz != 3'b010) begin
      e = 1'b1;
    end else begin
      case (a)
        OFF_RXDATA:               e = wr || !rxf;
        OFF_TXDATA:               e = !wr || txf;
        OFF_RXSTATE, OFF_TXSTATE: e = wr;
        default:                  e = 1'b0;
      endcase
    end
    return e;
  endfunction

  assign accept = hsel && htrans[1] && hready;

  // The error verdict is formed at the address-phase edge from the next-state
  // values, i.e. exactly the state the data phase starts with. That lets
  // hreadyout/hresp come straight from flops while ERR1 still coincides with
  // the first data-phase cycle.
  assign addr_err = decode_err(haddr[4:0], hwrite, hsize, rx_full_nxt, count_nxt == DEPTH_P);

  // Only an OKAY data phase reaches ST_OKAY with pending set.
  assign commit = pending && (state == ST_OKAY);

  always_ff @(posedge clk) begin
    if (nReset) begin
      state     <= ST_OKAY;
      hreadyout <= 1'b1;
      hresp     <= 1'b0;
      pending   <= 1'b0;
      d_addr    <= '0;
      d_write   <= 1'b0;
    end else begin
      pending <= accept;
      if (accept) begin
        d_addr  <= haddr[4:0];
        d_write <= hwrite;
      end
      case (state)
        ST_ERR1: begin
          state     <= ST_ERR2;
          hreadyout <= 1'b1;
          hresp     <= 1'b1;
        end
        default: begin
          // ST_OKAY and ST_ERR2 both take a new address phase normally.
          if (accept && addr_err) begin
            state     <= ST_ERR1;
            hreadyout <= 1'b0;
            hresp     <= 1'b1;
          end else begin
            state     <= ST_OKAY;
            hreadyout <= 1'b1;
            hresp     <= 1'b0;
          end
        end
      endcase
    end
  end

  always_comb begin
    hrdata = '0;
    if (commit && !d_write) begin
      case (d_addr)
        OFF_RXDATA:  hrdata = {24'b0, rx_hold};
        OFF_RXSTATE: hrdata = {30'b0, rx_ovr, rx_full};
        OFF_TXSTATE: hrdata = {16'b0, cnt8, 6'b0, full, empty};
        OFF_BAUD:    hrdata = {16'b0, baud_q};
        default:     hrdata = '0;
      endcase
    end
  end

  // RX holding register. A pop in the same cycle as a strobe makes room, so
  // the new byte is taken and no overrun is recorded.
  assign rx_pop      = commit && !d_write && (d_addr == OFF_RXDATA);
  assign rx_ovr_clr  = commit && !d_write && (d_addr == OFF_RXSTATE);
  assign rx_full_nxt = rx_strobe || (rx_full && !rx_pop);

  always_ff @(posedge clk) begin
    if (nReset) begin
      rx_hold <= '0;
      rx_full <= 1'b0;
      rx_ovr  <= 1'b0;
    end else begin
      rx_full <= rx_full_nxt;
      if (rx_strobe && (!rx_full || rx_pop)) begin
        rx_hold <= rx_byte;
      end
      // Set has priority over the read-to-clear.
      if (rx_strobe && rx_full && !rx_pop) begin
        rx_ovr <= 1'b1;
      end else if (rx_ovr_clr) begin
        rx_ovr <= 1'b0;
      end
    end
  end

  // TX FIFO: pointers carry one extra wrap bit so full and empty differ.
  assign count     = wr_ptr - rd_ptr;
  assign empty     = (count == '0);
  assign full      = (count == DEPTH_P);
  assign cnt8      = 8'(count);
  assign tx_valid  = !empty;
  assign tx_byte   = tx_valid ? mem[rd_ptr[AW-1:0]] : 8'h00;
  assign tx_push   = commit && d_write && (d_addr == OFF_TXDATA);
  assign tx_pop    = tx_valid && tx_ready;
  assign count_nxt = count + PW'(tx_push) - PW'(tx_pop);

  always_ff @(posedge clk) begin
    if (nReset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (tx_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (tx_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (tx_push && !nReset) begin
      mem[wr_ptr[AW-1:0]] <= hwdata[7:0];
    end
  end

  // A divisor of 0 would stall the shift engines, so it is stored as 1.
  always_ff @(posedge clk) begin
    if (nReset) begin
      baud_q <= BAUD_RST;
    end else if (commit && d_write && (d_addr == OFF_BAUD)) begin
      baud_q <= (hwdata[15:0] == 16'd0) ? 16'd1 : hwdata[15:0];
    end
  end

  assign baud_div = baud_q;

endmodule

// File: doc/ahb_uart_regs.md
Name: ahb_uart_regs

Overview:
- AHB-Lite subordinate (responder) for the UART register map.
- Decodes bus transfers and owns the TX byte FIFO, the RX holding register, the status registers and the baud divisor.
- Sits between the AHB interconnect and the UART TX/RX shift engines.
- Serves the same five-word map the bus-side controller sequences through.

Parameters:
- ADDR_W, 32, haddr width; only haddr[4:0] is decoded.
- TX_DEPTH, 4, TX FIFO entries; power of two, at least 2.
- BAUD_RST, 16'd434, baud_div reset value.

Ports:
- clk  in  1  system clock
- nReset  in  1  synchronous, active-high reset (1 = reset), sampled on the rising edge of clk
- hsel  in  1  subordinate select
- haddr  in  ADDR_W  address
- htrans  in  2  transfer type; NONSEQ/SEQ are active
- hwrite  in  1  1 = write
- hsize  in  3  transfer size; only 3'b010 (word) is legal
- hwdata  in  32  write data, valid in the data phase
- hready  in  1  bus-wide ready
- hreadyout  out  1  subordinate ready
- hresp  out  1  1 = ERROR
- hrdata  out  32  read data
- rx_byte  in  8  received byte from the RX engine
- rx_strobe  in  1  one-cycle pulse: rx_byte is valid
- tx_byte  out  8  FIFO head byte
- tx_valid  out  1  FIFO not empty
- tx_ready  in  1  TX engine accepts the head byte (pop when tx_valid && tx_ready)
- baud_div  out  16  baud divisor

Behaviour:
- Reset values:
  - hreadyout=1, hresp=0, hrdata=0
  - TX FIFO empty, so tx_valid=0 and tx_byte=0
  - rx_full=0, rx_ovr=0
  - baud_div=BAUD_RST
  - data-phase pending flag=0
- Reset mid-transfer abandons the transfer; no FIFO push or pop, and no register update.
- Address phase is accepted when hsel && htrans[1] && hready. On acceptance, capture addr[4:0], hwrite and hsize, and set pending for the next cycle (data phase).
- Register map (word offsets):
  - 0x00 RXDATA (RO): hrdata={24'b0,rx_hold}; a read clears rx_full.
  - 0x04 TXDATA (WO): pushes hwdata[7:0].
  - 0x08 RXSTATE (RO): {30'b0,rx_ovr,rx_full}; a read clears rx_ovr.
  - 0x0C TXSTATE (RO): {16'b0, count[7:0], 6'b0, full, empty}, where count is the FIFO occupancy.
  - 0x10 BAUD (RW): [15:0]=baud_div. A written value of 0 is stored as 1.
- Okay data phase: zero wait states (hreadyout=1, hresp=0). For reads, hrdata is valid in the same cycle. The side effect (push, pop, clear, baud update) commits at the clock edge ending the data phase.
- Error conditions, evaluated on state at data-phase start:
  - unmapped offset (>0x10) or an offset with addr[1:0]≠0
  - hsize≠word
  - write to a RO register, or read of TXDATA
  - RXDATA read with rx_full=0
  - TXDATA write with FIFO full, even if a tx pop occurs the same cycle
- Error response takes two cycles, driven by a small FSM: OKAY → ERR1 (hreadyout=0, hresp=1) → ERR2 (hreadyout=1, hresp=1) → OKAY.
  - An errored transfer has no side effects.
  - In ERR2, a new address phase is accepted normally.
  - During ERR1, no address phase is accepted, because hready=0 on the bus.
- Idle/BUSY or unselected data phase: OKAY, hrdata=0.
- RX holding register:
  - A rx_strobe with rx_full=0 loads rx_hold and sets rx_full.
  - A rx_strobe with rx_full=1 and no RXDATA pop the same cycle drops the byte and sets rx_ovr (sticky).
  - A rx_strobe coinciding with an RXDATA pop loads the new byte; rx_full stays 1 and no overrun is flagged.
- RXSTATE read coinciding with a new overrun: rx_ovr stays 1, because set wins over clear.
- TX FIFO:
  - Circular buffer; pointers are log2(TX_DEPTH)+1 bits wide and wrap.
  - A simultaneous push and pop when not full keeps count unchanged.
  - A pop when empty is impossible because tx_valid=0.
  - tx_byte is the head entry, combinational from the read pointer.
- Back-to-back transfers: each data phase overlaps the next address phase. Pipelined write-then-read of TXSTATE returns the post-push count.

Test Plan:
- Reset, then read 0x10 → hrdata=0x000001B2, OKAY. Read 0x0C → 0x00000001 (empty).
- Write 0x41, 0x42, 0x43, 0x44 to 0x04 with tx_ready=0 → TXSTATE=0x00000402 (count=4, full). A 5th write → two-cycle ERROR, count stays 4. Set tx_ready=1 → tx_byte emits 0x41, 0x42, 0x43, 0x44 in order, then tx_valid=0.
- rx_strobe with 0x5A → RXSTATE=0x1. Read 0x00 → 0x5A, then RXSTATE=0x0. Read 0x00 again → ERROR.
- Two rx_strobe pulses (0x11, 0x22) with no read → RXSTATE=0x3 and RXDATA=0x11. Read RXSTATE → rx_ovr clears on the next read (0x1).
- rx_strobe of 0x77 in the same cycle as an RXDATA pop of 0x11 → RXDATA read returns 0x11, rx_full stays 1, next RXDATA read returns 0x77, rx_ovr=0.
- Error checks:
  - write 0 to 0x10 → baud_div=1
  - write to 0x08 → ERROR
  - access 0x14 → ERROR
  - hsize=byte on 0x04 → ERROR
  - assert nReset during an ERR1 cycle → next cycle hreadyout=1, hresp=0, all state at reset values
